mmio_console: RTL and testbench

Memory-mapped byte console that responds to the 6502 core's bus (addr/dor/RW). The responder timing matches the block RAM, so the top level can mux its read data beside the RAM's. Bus writes push bytes into a TX FIFO that drains through a valid/ready stream toward an external sink such as a UART TX or the testbench. A single-byte RX holding register accepts bytes from a valid/ready source and presents them to the CPU, with status, control and IRQ support.

---
 rtl/mmio_console_if.sv | 28 ++
 rtl/mmio_console.sv | 149 ++++++++++++++
 tb/tb_mmio_console.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_console_if.sv
// CPU bus, TX stream, RX stream and IRQ signals of the MMIO byte console.
interface mmio_console_if;
  logic [15:0] i_addr;
  logic [7:0]  i_wdata;
  logic        i_rw;
  logic        i_en;
  logic [7:0]  o_rdata;
  logic        o_sel;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic        o_irq;

  // Console side: responds to the bus, sources TX, sinks RX.
  modport slave (
    input  i_addr, i_wdata, i_rw, i_en, i_tx_ready, i_rx_data, i_rx_valid,
    output o_rdata, o_sel, o_tx_data, o_tx_valid, o_rx_ready, o_irq
  );

  // CPU / environment side.
  modport master (
    output i_addr, i_wdata, i_rw, i_en, i_tx_ready, i_rx_data, i_rx_valid,
    input  o_rdata, o_sel, o_tx_data, o_tx_valid, o_rx_ready, o_irq
  );
endinterface

// File: rtl/mmio_console.sv
// Memory-mapped byte console: 4-register window with TX FIFO, RX holding
// register, status/control and a level IRQ. Read timing matches block RAM.
module mmio_console #(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input logic           i_clk,
  input logic           i_rst,
  mmio_console_if.slave bus
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_COUNT  = 2'd3;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [1:0]    r_ctrl;
  logic          r_rx_full;
  logic [7:0]    r_rx_data;
  logic [7:0]    r_rdata;
  logic          r_sel;

  logic       w_hit;
  logic       w_acc;
  logic       w_rd;
  logic       w_wr;
  logic [1:0] w_off;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_ovf_set;
  logic       w_ovf_clr;
  logic       w_rx_ready;
  logic       w_rx_accept;
  logic       w_rx_pop;
  logic [7:0] w_rd_val;

  // Address decode and access qualification.
  always_comb begin
    w_hit = (bus.i_addr[15:2] == BASE_ADDR[15:2]);
    w_off = bus.i_addr[1:0];
    w_acc = w_hit & bus.i_en;
    w_rd  = w_acc & bus.i_rw;
    w_wr  = w_acc & ~bus.i_rw;
  end

  // FIFO flags, push/pop decisions and RX handshake.
  always_comb begin
    w_full      = (r_count == CW'(FIFO_DEPTH));
    w_empty     = (r_count == '0);
    w_pop       = ~w_empty & bus.i_tx_ready;
    w_push      = w_wr & (w_off == OFF_DATA) & ~w_full;
    w_ovf_set   = w_wr & (w_off == OFF_DATA) & w_full;
    w_ovf_clr   = w_wr & (w_off == OFF_STATUS) & bus.i_wdata[4];
    w_rx_ready  = ~r_rx_full & ~i_rst;
    w_rx_accept = bus.i_rx_valid & w_rx_ready;
    w_rx_pop    = w_rd & (w_off == OFF_DATA) & r_rx_full;
  end

  // Register read mux.
  always_comb begin
    w_rd_val = 8'h00;
    case (w_off)
      OFF_DATA:   w_rd_val = r_rx_full ? r_rx_data : 8'h00;
      OFF_STATUS: w_rd_val = {3'b000, r_ovf, 1'b0, r_rx_full, w_empty, w_full};
      OFF_CTRL:   w_rd_val = {6'b000000, r_ctrl};
      OFF_COUNT:  w_rd_val = 8'(r_count);
      default:    w_rd_val = 8'h00;
    endcase
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= bus.i_wdata;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag and control register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf  <= 1'b0;
      r_ctrl <= 2'b00;
    end else begin
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      if (w_wr && (w_off == OFF_CTRL)) r_ctrl <= bus.i_wdata[1:0];
    end
  end

  // RX holding register; accept and CPU pop are mutually exclusive.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_full <= 1'b0;
      r_rx_data <= 8'h00;
    end else if (w_rx_accept) begin
      r_rx_full <= 1'b1;
      r_rx_data <= bus.i_rx_data;
    end else if (w_rx_pop) begin
      r_rx_full <= 1'b0;
    end
  end

  // One-cycle registered read response, zero when not selected.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= 8'h00;
      r_sel   <= 1'b0;
    end else if (w_rd) begin
      r_rdata <= w_rd_val;
      r_sel   <= 1'b1;
    end else begin
      r_rdata <= 8'h00;
      r_sel   <= 1'b0;
    end
  end

  assign bus.o_rdata    = r_rdata;
  assign bus.o_sel      = r_sel;
  assign bus.o_tx_data  = r_mem[r_rptr];
  assign bus.o_tx_valid = ~w_empty;
  assign bus.o_rx_ready = w_rx_ready;
  assign bus.o_irq      = (r_ctrl[0] & r_rx_full) | (r_ctrl[1] & w_empty);

endmodule

// File: tb/tb_mmio_console.sv
// Testbench for mmio_console: vector table, corner sequences and random
// traffic checked against a queue-based model of the register map.
module tb_mmio_console;

  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mmio_console_if bus ();

  mmio_console #(.BASE_ADDR(16'hFF00), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [7:0] mq[$];
  logic       m_rx_full = 1'b0;
  logic [7:0] m_rx_data = 8'h00;
  logic       m_ovf     = 1'b0;
  logic [1:0] m_ctrl    = 2'b00;
  logic       m_sel     = 1'b0;
  logic [7:0] m_rdata   = 8'h00;

  typedef struct {
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic        rw;
    logic        en;
    logic        txr;
    logic [7:0]  rxd;
    logic        rxv;
    logic        e_sel;
    logic [7:0]  e_rdata;
    logic        e_txv;
    logic [7:0]  e_txd;
    logic        e_rxrdy;
    logic        e_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge(input logic r, input logic [15:0] a, input logic [7:0] wd,
                            input logic rw, input logic en, input logic txr,
                            input logic [7:0] rxd, input logic rxv);
    logic acc, rd, wr, full_pre, do_pop, do_push, accept, rxpop;
    logic [1:0] off;
    if (r) begin
      mq.delete();
      m_rx_full = 1'b0; m_rx_data = 8'h00; m_ovf = 1'b0; m_ctrl = 2'b00;
      m_sel = 1'b0; m_rdata = 8'h00;
      return;
    end
    acc = (a[15:2] == 14'h3FC0) && en;
    off = a[1:0];
    rd  = acc && rw;
    wr  = acc && !rw;
    if (rd) begin
      m_sel = 1'b1;
      case (off)
        2'd0:    m_rdata = m_rx_full ? m_rx_data : 8'h00;
        2'd1:    m_rdata = {3'b000, m_ovf, 1'b0, m_rx_full, mq.size() == 0, mq.size() == DEPTH};
        2'd2:    m_rdata = {6'b000000, m_ctrl};
        default: m_rdata = 8'(mq.size());
      endcase
    end else begin
      m_sel = 1'b0; m_rdata = 8'h00;
    end
    full_pre = (mq.size() == DEPTH);
    do_pop   = (mq.size() != 0) && txr;
    accept   = rxv && !m_rx_full;
    rxpop    = rd && off == 2'd0 && m_rx_full;
    do_push  = 1'b0;
    if (wr) begin
      if (off == 2'd0) begin
        if (full_pre) m_ovf = 1'b1;
        else do_push = 1'b1;
      end else if (off == 2'd1) begin
        if (wd[4]) m_ovf = 1'b0;
      end else if (off == 2'd2) begin
        m_ctrl = wd[1:0];
      end
    end
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(wd);
    if (rxpop) m_rx_full = 1'b0;
    if (accept) begin
      m_rx_full = 1'b1; m_rx_data = rxd;
    end
  endtask

  // Drive one cycle, step the model, sample #1 after the edge and compare.
  task automatic step(input logic r, input logic [15:0] a, input logic [7:0] wd,
                      input logic rw, input logic en, input logic txr,
                      input logic [7:0] rxd, input logic rxv);
    logic e_irq;
    rst = r;
    bus.i_addr = a; bus.i_wdata = wd; bus.i_rw = rw; bus.i_en = en;
    bus.i_tx_ready = txr; bus.i_rx_data = rxd; bus.i_rx_valid = rxv;
    model_edge(r, a, wd, rw, en, txr, rxd, rxv);
    @(posedge clk);
    #1;
    e_irq = (m_ctrl[0] && m_rx_full) || (m_ctrl[1] && mq.size() == 0);
    chk("m_sel", 32'(bus.o_sel), 32'(m_sel));
    chk("m_rdata", 32'(bus.o_rdata), 32'(m_rdata));
    chk("m_tx_valid", 32'(bus.o_tx_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("m_tx_data", 32'(bus.o_tx_data), 32'(mq[0]));
    chk("m_rx_ready", 32'(bus.o_rx_ready), 32'(!m_rx_full && !r));
    chk("m_irq", 32'(bus.o_irq), 32'(e_irq));
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic txr);
    step(1'b0, a, d, 1'b0, 1'b1, txr, 8'h00, 1'b0);
  endtask

  task automatic rd(input logic [15:0] a, input logic txr);
    step(1'b0, a, 8'h00, 1'b1, 1'b1, txr, 8'h00, 1'b0);
  endtask

  task automatic idle(input logic txr);
    step(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, txr, 8'h00, 1'b0);
  endtask

  task automatic add(input logic r, input logic [15:0] a, input logic [7:0] wd,
                     input logic rw, input logic en, input logic txr,
                     input logic [7:0] rxd, input logic rxv,
                     input logic s, input logic [7:0] rdv, input logic txv,
                     input logic [7:0] txd, input logic rxr, input logic irq);
    vec_t v;
    v = '{r, a, wd, rw, en, txr, rxd, rxv, s, rdv, txv, txd, rxr, irq};
    vecs.push_back(v);
  endtask

  initial begin
    bus.i_addr = 16'h0000; bus.i_wdata = 8'h00; bus.i_rw = 1'b1; bus.i_en = 1'b0;
    bus.i_tx_ready = 1'b0; bus.i_rx_data = 8'h00; bus.i_rx_valid = 1'b0;

    //   rst addr      wd    rw en txr rxd   rxv | sel rdata txv txd   rxr irq
    add(1, 16'h0000, 8'h00, 1, 1, 0, 8'h00, 0,   0, 8'h00, 0, 8'h00, 0, 0);
    add(0, 16'hFF01, 8'h00, 1, 1, 0, 8'h00, 0,   1, 8'h02, 0, 8'h00, 1, 0);
    add(0, 16'hFF00, 8'h41, 0, 1, 0, 8'h00, 0,   0, 8'h00, 1, 8'h41, 1, 0);
    add(0, 16'hFF00, 8'h42, 0, 1, 0, 8'h00, 0,   0, 8'h00, 1, 8'h41, 1, 0);
    add(0, 16'hFF00, 8'h43, 0, 1, 0, 8'h00, 0,   0, 8'h00, 1, 8'h41, 1, 0);
    add(0, 16'hFF03, 8'h00, 1, 1, 0, 8'h00, 0,   1, 8'h03, 1, 8'h41, 1, 0);
    add(0, 16'h0000, 8'h00, 1, 1, 1, 8'h00, 0,   0, 8'h00, 1, 8'h42, 1, 0);
    add(0, 16'h0000, 8'h00, 1, 1, 1, 8'h00, 0,   0, 8'h00, 1, 8'h43, 1, 0);
    add(0, 16'h0000, 8'h00, 1, 1, 1, 8'h00, 0,   0, 8'h00, 0, 8'h00, 1, 0);
    add(0, 16'hFF01, 8'h00, 1, 1, 1, 8'h00, 0,   1, 8'h02, 0, 8'h00, 1, 0);
    add(0, 16'hFF02, 8'h01, 0, 1, 0, 8'h00, 0,   0, 8'h00, 0, 8'h00, 1, 0);
    add(0, 16'h0000, 8'h00, 1, 1, 0, 8'h5A, 1,   0, 8'h00, 0, 8'h00, 0, 1);
    add(0, 16'hFF00, 8'h00, 1, 1, 0, 8'hA5, 1,   1, 8'h5A, 0, 8'h00, 1, 0);
    add(0, 16'h0000, 8'h00, 1, 1, 0, 8'hA5, 1,   0, 8'h00, 0, 8'h00, 0, 1);
    add(0, 16'hFF00, 8'h00, 1, 1, 0, 8'h00, 0,   1, 8'hA5, 0, 8'h00, 1, 0);
    add(0, 16'hFF00, 8'h00, 1, 1, 0, 8'h00, 0,   1, 8'h00, 0, 8'h00, 1, 0);
    add(0, 16'hFF02, 8'hFF, 0, 1, 0, 8'h00, 0,   0, 8'h00, 0, 8'h00, 1, 1);
    add(0, 16'hFF02, 8'h00, 1, 1, 0, 8'h00, 0,   1, 8'h03, 0, 8'h00, 1, 1);
    add(0, 16'hFF02, 8'h00, 0, 1, 0, 8'h00, 0,   0, 8'h00, 0, 8'h00, 1, 0);
    add(0, 16'hFF02, 8'h00, 1, 1, 0, 8'h00, 0,   1, 8'h00, 0, 8'h00, 1, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].addr, vecs[i].wd, vecs[i].rw, vecs[i].en,
           vecs[i].txr, vecs[i].rxd, vecs[i].rxv);
      chk($sformatf("v%0d_sel", i), 32'(bus.o_sel), 32'(vecs[i].e_sel));
      chk($sformatf("v%0d_rdata", i), 32'(bus.o_rdata), 32'(vecs[i].e_rdata));
      chk($sformatf("v%0d_txv", i), 32'(bus.o_tx_valid), 32'(vecs[i].e_txv));
      if (vecs[i].e_txv) chk($sformatf("v%0d_txd", i), 32'(bus.o_tx_data), 32'(vecs[i].e_txd));
      chk($sformatf("v%0d_rxrdy", i), 32'(bus.o_rx_ready), 32'(vecs[i].e_rxrdy));
      chk($sformatf("v%0d_irq", i), 32'(bus.o_irq), 32'(vecs[i].e_irq));
    end

    // Overflow: 17 writes into a 16-deep FIFO, drain, clear OVF.
    for (int i = 0; i <= 16; i++) wr(16'hFF00, 8'(i), 1'b0);
    rd(16'hFF01, 1'b0);
    chk("ovf_status", 32'(bus.o_rdata), 32'h11);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain", 32'(bus.o_tx_data), 32'(i));
      idle(1'b1);
    end
    chk("ovf_drained", 32'(bus.o_tx_valid), 32'h0);
    wr(16'hFF01, 8'h10, 1'b0);
    rd(16'hFF01, 1'b0);
    chk("ovf_clear", 32'(bus.o_rdata), 32'h02);

    // Steady state at DEPTH-1 with simultaneous push/pop across pointer wrap.
    for (int i = 0; i < int'(DEPTH) - 1; i++) wr(16'hFF00, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 40; i++) wr(16'hFF00, 8'(8'h80 + i), 1'b1);
    rd(16'hFF03, 1'b0);
    chk("wrap_count", 32'(bus.o_rdata), 32'(DEPTH - 1));
    rd(16'hFF01, 1'b0);
    chk("wrap_status", 32'(bus.o_rdata), 32'h00);
    chk("wrap_head", 32'(bus.o_tx_data), 32'(8'h80 + 40 - (DEPTH - 1)));
    for (int i = 0; i < int'(DEPTH); i++) idle(1'b1);
    chk("wrap_empty", 32'(bus.o_tx_valid), 32'h0);

    // Non-hit and disabled accesses have no effect; reset flushes state.
    wr(16'hFF00, 8'h77, 1'b0);
    step(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 8'h33, 1'b1);
    step(1'b0, 16'hFE00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("miss_fe00_rd", 32'(bus.o_sel), 32'h0);
    step(1'b0, 16'hFF04, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("miss_ff04_rd", 32'(bus.o_sel), 32'h0);
    step(1'b0, 16'hFE00, 8'h99, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 16'hFF04, 8'h99, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 16'hFF00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("en0_rd", 32'(bus.o_sel), 32'h0);
    step(1'b0, 16'hFF00, 8'h99, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    rd(16'hFF03, 1'b0);
    chk("miss_count", 32'(bus.o_rdata), 32'h01);
    rd(16'hFF00, 1'b0);
    chk("miss_rx", 32'(bus.o_rdata), 32'h33);
    for (int i = 0; i < 5; i++) wr(16'hFF00, 8'(8'hC0 + i), 1'b0);
    step(1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    rd(16'hFF03, 1'b0);
    chk("rst_count", 32'(bus.o_rdata), 32'h00);
    chk("rst_txv", 32'(bus.o_tx_valid), 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int unsigned sel;
      logic [15:0] a;
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = 16'hFF00 | 16'($urandom_range(0, 3));
      else if (sel == 7) a = 16'hFE00 | 16'($urandom_range(0, 3));
      else if (sel == 8) a = 16'hFF04 | 16'($urandom_range(0, 3));
      else               a = 16'($urandom);
      step($urandom_range(0, 199) == 0, a, 8'($urandom), 1'($urandom),
           $urandom_range(0, 4) != 0, 1'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
